// File: rtl/dec_lane_status.sv
// Per-lane 8b/10b receive status: merges sub-decoder flags, tracks running disparity,
// counts bad symbols and runs a comma-based sync FSM. Every lane is fully independent.
module dec_lane_status #(
  parameter int NUM_LANES  = 4,
  parameter int ERR_CNT_W  = 16,
  parameter int ACQ_COMMAS = 3,
  parameter int ERR_LIMIT  = 4,
  parameter int GOOD_RUN   = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_LANES-1:0]           in_valid,
  input  logic [10*NUM_LANES-1:0]        sym,
  input  logic [8*NUM_LANES-1:0]         data,
  input  logic [NUM_LANES-1:0]           code_err_lo,
  input  logic [NUM_LANES-1:0]           code_err_hi,
  input  logic [NUM_LANES-1:0]           kout_lo,
  input  logic [NUM_LANES-1:0]           kout_hi,
  input  logic                           cnt_clear,
  output logic [NUM_LANES-1:0]           out_valid,
  output logic [NUM_LANES-1:0]           kout,
  output logic [NUM_LANES-1:0]           code_err,
  output logic [NUM_LANES-1:0]           disp_err,
  output logic [NUM_LANES-1:0]           rdisp,
  output logic [NUM_LANES-1:0]           sync,
  output logic [NUM_LANES-1:0]           sync_lost,
  output logic [ERR_CNT_W*NUM_LANES-1:0] err_cnt
);

  localparam int AW = $clog2(ACQ_COMMAS + 1);
  localparam int CW = $clog2(ERR_LIMIT + 1);
  localparam int RW = $clog2(GOOD_RUN + 1);
  localparam logic [AW-1:0] ACQ_LAST    = AW'(ACQ_COMMAS - 1);
  localparam logic [CW-1:0] CREDIT_LAST = CW'(ERR_LIMIT - 1);
  localparam logic [RW-1:0] RUN_LAST    = RW'(GOOD_RUN - 1);

  typedef enum logic {ACQ, SYNC} state_t;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    state_t                 state_q, state_d;
    logic [AW-1:0]          acq_q, acq_d;
    logic [CW-1:0]          credit_q, credit_d;
    logic [RW-1:0]          run_q, run_d;
    logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   rd_q, rd_d;
    logic                   ov_q, ov_d, k_q, k_d, ce_q, ce_d, de_q, de_d, sl_q, sl_d;
    logic [3:0]             ones;
    logic                   pos, neg, illegal, bad, comma;

    // Symbol classification, disparity tracking and the sync FSM next-state logic.
    always_comb begin
      ones    = 4'($countones(sym[10*i +: 10]));
      pos     = (ones == 4'd6);
      neg     = (ones == 4'd4);
      illegal = (ones != 4'd5) && !pos && !neg;

      ov_d = in_valid[i];
      k_d  = in_valid[i] & (kout_lo[i] | kout_hi[i]);
      ce_d = in_valid[i] & (code_err_lo[i] | code_err_hi[i] | illegal);
      de_d = in_valid[i] & ((pos & rd_q) | (neg & ~rd_q));

      rd_d = rd_q;
      if (in_valid[i] && pos)      rd_d = 1'b1;
      else if (in_valid[i] && neg) rd_d = 1'b0;

      bad   = ce_d | de_d;
      comma = k_d & (data[8*i +: 8] == 8'hBC) & ~bad;

      // Clear wins over a same-cycle increment; the increment is simply lost.
      cnt_d = cnt_q;
      if (cnt_clear)                 cnt_d = '0;
      else if (bad && cnt_q != '1)   cnt_d = cnt_q + ERR_CNT_W'(1);

      state_d  = state_q;
      acq_d    = acq_q;
      credit_d = credit_q;
      run_d    = run_q;
      sl_d     = 1'b0;
      if (in_valid[i]) begin
        case (state_q)
          ACQ: begin
            if (!comma) begin
              acq_d = '0;
            end else if (acq_q == ACQ_LAST) begin
              state_d  = SYNC;
              acq_d    = '0;
              credit_d = '0;
              run_d    = '0;
            end else begin
              acq_d = acq_q + AW'(1);
            end
          end
          SYNC: begin
            if (bad) begin
              run_d = '0;
              if (credit_q == CREDIT_LAST) begin
                state_d  = ACQ;
                acq_d    = '0;
                credit_d = '0;
                sl_d     = 1'b1;
              end else begin
                credit_d = credit_q + CW'(1);
              end
            end else if (run_q == RUN_LAST) begin
              run_d = '0;
              if (credit_q != '0) credit_d = credit_q - CW'(1);
            end else begin
              run_d = run_q + RW'(1);
            end
          end
          default: state_d = ACQ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state_q  <= ACQ;
        acq_q    <= '0;
        credit_q <= '0;
        run_q    <= '0;
        cnt_q    <= '0;
        rd_q     <= 1'b0;
        ov_q     <= 1'b0;
        k_q      <= 1'b0;
        ce_q     <= 1'b0;
        de_q     <= 1'b0;
        sl_q     <= 1'b0;
      end else begin
        state_q  <= state_d;
        acq_q    <= acq_d;
        credit_q <= credit_d;
        run_q    <= run_d;
        cnt_q    <= cnt_d;
        rd_q     <= rd_d;
        ov_q     <= ov_d;
        k_q      <= k_d;
        ce_q     <= ce_d;
        de_q     <= de_d;
        sl_q     <= sl_d;
      end
    end

    assign out_valid[i] = ov_q;
    assign kout[i]      = k_q;
    assign code_err[i]  = ce_q;
    assign disp_err[i]  = de_q;
    assign rdisp[i]     = rd_q;
    assign sync[i]      = (state_q == SYNC);
    assign sync_lost[i] = sl_q;
    assign err_cnt[ERR_CNT_W*i +: ERR_CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_dec_lane_status.sv
// Directed bench for dec_lane_status: two lanes, 2-bit counters, lane 1 left idle.
module tb_dec_lane_status;

  localparam int NL = 2;
  localparam int CW = 2;

  localparam logic [9:0] KM  = 10'b0011111010;  // K28.5 RD-, p=6
  localparam logic [9:0] KP  = 10'b1100000101;  // K28.5 RD+, p=4
  localparam logic [9:0] DN  = 10'b1010101010;  // neutral, p=5
  localparam logic [9:0] DP  = 10'b1111110000;  // p=6
  localparam logic [9:0] DG  = 10'b0000001111;  // p=4
  localparam logic [9:0] ILL = 10'b1111111111;  // p=10

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NL-1:0]     in_valid;
  logic [10*NL-1:0]  sym;
  logic [8*NL-1:0]   data;
  logic [NL-1:0]     code_err_lo, code_err_hi, kout_lo, kout_hi;
  logic              cnt_clear;
  logic [NL-1:0]     out_valid, kout, code_err, disp_err, rdisp, sync, sync_lost;
  logic [CW*NL-1:0]  err_cnt;

  int compared   = 0;
  int mismatched = 0;

  dec_lane_status #(.NUM_LANES(NL), .ERR_CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .sym(sym), .data(data),
    .code_err_lo(code_err_lo), .code_err_hi(code_err_hi),
    .kout_lo(kout_lo), .kout_hi(kout_hi), .cnt_clear(cnt_clear),
    .out_valid(out_valid), .kout(kout), .code_err(code_err), .disp_err(disp_err),
    .rdisp(rdisp), .sync(sync), .sync_lost(sync_lost), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Drive lane 0 for one clock, then sample just after the edge that captured it.
  task automatic applyStimulus(input logic v, input logic [9:0] s, input logic [7:0] d,
                               input logic klo, input logic khi, input logic celo,
                               input logic cehi, input logic clr);
    @(negedge clk);
    in_valid    = {1'b0, v};
    sym         = {10'b0, s};
    data        = {8'b0, d};
    kout_lo     = {1'b0, klo};
    kout_hi     = {1'b0, khi};
    code_err_lo = {1'b0, celo};
    code_err_hi = {1'b0, cehi};
    cnt_clear   = clr;
    @(posedge clk);
    #1;
  endtask

  // Expected layout: {out_valid, kout, code_err, disp_err, rdisp, sync, sync_lost, err_cnt[1:0]}
  task automatic checkOutput(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {out_valid[0], kout[0], code_err[0], disp_err[0], rdisp[0], sync[0],
           sync_lost[0], err_cnt[1:0]};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkLane1(input string tag);
    logic [8:0] obs;
    obs = {out_valid[1], kout[1], code_err[1], disp_err[1], rdisp[1], sync[1],
           sync_lost[1], err_cnt[3:2]};
    compared++;
    assert (obs === 9'b0) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, 9'b0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(0, '0, 8'h00, 0, 0, 0, 0, 0);
    applyStimulus(1, DP, 8'h00, 0, 0, 0, 0, 0);
    checkOutput("reset", 9'b0_0_0_0_0_0_0_00);
    checkLane1("reset_lane1");
    reset_n = 1'b1;

    applyStimulus(1, KM, 8'hBC, 1, 0, 0, 0, 0);
    checkOutput("t1_k285_rdminus", 9'b1_1_0_0_1_0_0_00);
    applyStimulus(0, '0, 8'h00, 0, 0, 0, 0, 0);
    checkOutput("t3_gap1", 9'b0_0_0_0_1_0_0_00);
    applyStimulus(1, KP, 8'hBC, 1, 0, 0, 0, 0);
    checkOutput("t3_comma2", 9'b1_1_0_0_0_0_0_00);
    applyStimulus(0, '0, 8'h00, 0, 0, 0, 0, 0);
    checkOutput("t3_gap2", 9'b0_0_0_0_0_0_0_00);
    applyStimulus(1, KM, 8'hBC, 1, 0, 0, 0, 0);
    checkOutput("t3_sync", 9'b1_1_0_0_1_1_0_00);

    applyStimulus(1, DN, 8'hB5, 0, 0, 0, 0, 0);
    checkOutput("t5_clean", 9'b1_0_0_0_1_1_0_00);
    applyStimulus(1, DP, 8'h00, 0, 0, 0, 0, 0);
    checkOutput("t5_bad1", 9'b1_0_0_1_1_1_0_01);
    for (int n = 0; n < 8; n++) begin
      applyStimulus(1, DN, 8'hB5, 0, 0, 0, 0, 0);
      checkOutput("t5_run", 9'b1_0_0_0_1_1_0_01);
    end
    applyStimulus(1, DP, 8'h00, 0, 0, 0, 0, 0);
    checkOutput("t5_bad2", 9'b1_0_0_1_1_1_0_10);
    applyStimulus(1, DP, 8'h00, 0, 0, 0, 0, 0);
    checkOutput("t5_bad3", 9'b1_0_0_1_1_1_0_11);
    applyStimulus(1, DP, 8'h00, 0, 0, 0, 0, 0);
    checkOutput("t5_credit3_still_sync", 9'b1_0_0_1_1_1_0_11);
    applyStimulus(1, DP, 8'h00, 0, 0, 0, 0, 0);
    checkOutput("t6_saturate_and_drop", 9'b1_0_0_1_1_0_1_11);
    applyStimulus(0, '0, 8'h00, 0, 0, 0, 0, 0);
    checkOutput("sync_lost_one_cycle", 9'b0_0_0_0_1_0_0_11);
    applyStimulus(1, DP, 8'h00, 0, 0, 0, 0, 1);
    checkOutput("t6_clear_beats_inc", 9'b1_0_0_1_1_0_0_00);

    applyStimulus(1, DG, 8'h00, 0, 0, 0, 0, 0);
    checkOutput("t2_to_rdminus", 9'b1_0_0_0_0_0_0_00);
    applyStimulus(1, DP, 8'h00, 0, 0, 0, 0, 0);
    checkOutput("t2_first_pos", 9'b1_0_0_0_1_0_0_00);
    applyStimulus(1, DP, 8'h00, 0, 0, 0, 0, 0);
    checkOutput("t2_second_pos", 9'b1_0_0_1_1_0_0_01);
    applyStimulus(1, ILL, 8'h00, 0, 0, 0, 0, 0);
    checkOutput("illegal_popcount", 9'b1_0_1_0_1_0_0_10);
    applyStimulus(1, DN, 8'hB5, 0, 0, 0, 1, 0);
    checkOutput("subdec_code_err", 9'b1_0_1_0_1_0_0_11);
    applyStimulus(1, DN, 8'h00, 0, 1, 0, 0, 0);
    checkOutput("kout_hi_only", 9'b1_1_0_0_1_0_0_11);
    applyStimulus(0, '0, 8'h00, 0, 0, 0, 0, 1);
    checkOutput("clear_while_idle", 9'b0_0_0_0_1_0_0_00);

    applyStimulus(1, KP, 8'hBC, 1, 0, 0, 0, 0);
    checkOutput("acq_comma1", 9'b1_1_0_0_0_0_0_00);
    applyStimulus(1, DN, 8'hB5, 0, 0, 0, 0, 0);
    checkOutput("acq_break", 9'b1_0_0_0_0_0_0_00);
    applyStimulus(1, KM, 8'hBC, 1, 0, 0, 0, 0);
    checkOutput("acq_restart", 9'b1_1_0_0_1_0_0_00);
    applyStimulus(1, KP, 8'hBC, 1, 0, 0, 0, 0);
    checkOutput("acq_no_early_sync", 9'b1_1_0_0_0_0_0_00);
    applyStimulus(1, KM, 8'hBC, 1, 0, 0, 0, 0);
    checkOutput("acq_sync", 9'b1_1_0_0_1_1_0_00);

    applyStimulus(1, DP, 8'h00, 0, 0, 0, 0, 0);
    checkOutput("t4_bad1", 9'b1_0_0_1_1_1_0_01);
    applyStimulus(1, DP, 8'h00, 0, 0, 0, 0, 0);
    checkOutput("t4_bad2", 9'b1_0_0_1_1_1_0_10);
    applyStimulus(1, DP, 8'h00, 0, 0, 0, 0, 0);
    checkOutput("t4_bad3", 9'b1_0_0_1_1_1_0_11);
    applyStimulus(1, DP, 8'h00, 0, 0, 0, 0, 0);
    checkOutput("t4_bad4_lost", 9'b1_0_0_1_1_0_1_11);
    applyStimulus(0, '0, 8'h00, 0, 0, 0, 0, 0);
    checkOutput("t4_pulse_once", 9'b0_0_0_0_1_0_0_11);

    applyStimulus(1, KP, 8'hBC, 1, 0, 0, 0, 0);
    checkOutput("t6_reacq1", 9'b1_1_0_0_0_0_0_11);
    applyStimulus(1, KM, 8'hBC, 1, 0, 0, 0, 0);
    checkOutput("t6_reacq2", 9'b1_1_0_0_1_0_0_11);
    applyStimulus(1, KP, 8'hBC, 1, 0, 0, 0, 0);
    checkOutput("t6_presync", 9'b1_1_0_0_0_1_0_11);
    reset_n = 1'b0;
    applyStimulus(1, DP, 8'h00, 0, 0, 0, 0, 0);
    checkOutput("t6_reset_mid_sync", 9'b0_0_0_0_0_0_0_00);
    reset_n = 1'b1;
    applyStimulus(1, KM, 8'hBC, 1, 0, 0, 0, 0);
    checkOutput("t6_post_reset_acq", 9'b1_1_0_0_1_0_0_00);
    checkLane1("lane1_untouched");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
